niosii_system_sysid_timer: RTL and testbench



---
 rtl/niosii_system_sysid_timer.sv | 190 +++++++++++++++++++
 tb/tb_niosii_system_sysid_timer.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/niosii_system_sysid_timer.sv
// -----------------------------------------------------------------------------
// niosii_system_sysid_timer
//
// System-identification and uptime slave for the Nios II Avalon-MM fabric.
// Returns a fixed hardware ID and build timestamp. Also provides:
//   - a free-running 64-bit cycle counter, with the high word captured when the
//     low word is read so that a LO-then-HI read sequence never tears,
//   - a seconds counter driven by a CLK_FREQ_HZ prescaler,
//   - a byte-writable scratch register,
//   - a control register (self-clearing counter clear, sticky FREEZE).
//
// Word map: 0 ID, 1 TIMESTAMP, 2 CYCLES_LO, 3 CYCLES_HI (captured),
//           4 SECONDS, 5 SCRATCH, 6 CONTROL, 7 reserved (reads 0).
//
// Ports:
//   clock          system clock, rising edge
//   reset          asynchronous active-high reset
//   address[2:0]   word address
//   read / write   single-cycle access strobes (the bus never stalls)
//   writedata[31:0], byteenable[3:0]   write payload and lane enables
//   readdata[31:0] registered read data, held between reads
//   readdatavalid  one-cycle pulse, one cycle after an accepted read
// -----------------------------------------------------------------------------
module niosii_system_sysid_timer #(
    parameter logic [31:0] SYSTEM_ID   = 32'h0000_0000,
    parameter logic [31:0] TIMESTAMP   = 32'h0000_0000,
    parameter int unsigned CLK_FREQ_HZ = 50_000_000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [2:0]  address,
    input  logic        read,
    input  logic        write,
    input  logic [31:0] writedata,
    input  logic [3:0]  byteenable,
    output logic [31:0] readdata,
    output logic        readdatavalid
);

    localparam logic [2:0] ADDR_ID      = 3'd0;
    localparam logic [2:0] ADDR_TSTAMP  = 3'd1;
    localparam logic [2:0] ADDR_CYC_LO  = 3'd2;
    localparam logic [2:0] ADDR_CYC_HI  = 3'd3;
    localparam logic [2:0] ADDR_SECONDS = 3'd4;
    localparam logic [2:0] ADDR_SCRATCH = 3'd5;
    localparam logic [2:0] ADDR_CONTROL = 3'd6;

    // Terminal prescaler count; the prescaler runs 0 .. CLK_FREQ_HZ-1.
    localparam logic [31:0] PRESC_LAST = 32'(CLK_FREQ_HZ - 32'd1);

    logic [63:0] cyc_r;
    logic [31:0] hi_shadow_r;
    logic [31:0] presc_r;
    logic [31:0] seconds_r;
    logic [31:0] scratch_r;
    logic        freeze_r;
    logic [31:0] readdata_r;
    logic        readdatavalid_r;

    logic        wr_ctrl_s;
    logic        clear_s;
    logic        wr_scratch_s;
    logic        rd_lo_s;
    logic        presc_wrap_s;
    logic [31:0] rd_mux_s;
    logic [31:0] scratch_next_s;

    // Decode bus strobes into per-register actions.
    always_comb begin
        wr_ctrl_s    = write && (address == ADDR_CONTROL) && byteenable[0];
        clear_s      = wr_ctrl_s && writedata[0];
        wr_scratch_s = write && (address == ADDR_SCRATCH);
        rd_lo_s      = read && (address == ADDR_CYC_LO);
        presc_wrap_s = (presc_r == PRESC_LAST);
    end

    // Read data selection from current (pre-write) register state.
    always_comb begin
        rd_mux_s = 32'h0000_0000;
        case (address)
            ADDR_ID:      rd_mux_s = SYSTEM_ID;
            ADDR_TSTAMP:  rd_mux_s = TIMESTAMP;
            ADDR_CYC_LO:  rd_mux_s = cyc_r[31:0];
            ADDR_CYC_HI:  rd_mux_s = hi_shadow_r;
            ADDR_SECONDS: rd_mux_s = seconds_r;
            ADDR_SCRATCH: rd_mux_s = scratch_r;
            ADDR_CONTROL: rd_mux_s = {30'd0, freeze_r, 1'b0};
            default:      rd_mux_s = 32'h0000_0000;
        endcase
    end

    // Byte-lane merge of write data into the scratch register.
    always_comb begin
        scratch_next_s = scratch_r;
        for (int i = 0; i < 4; i++) begin
            if (byteenable[i]) begin
                scratch_next_s[8*i +: 8] = writedata[8*i +: 8];
            end else begin
                scratch_next_s[8*i +: 8] = scratch_r[8*i +: 8];
            end
        end
    end

    // 64-bit cycle counter; a clear takes priority over the increment.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cyc_r <= 64'd0;
        end else if (clear_s) begin
            cyc_r <= 64'd0;
        end else if (!freeze_r) begin
            cyc_r <= cyc_r + 64'd1;
        end else begin
            cyc_r <= cyc_r;
        end
    end

    // Prescaler and seconds counter, gated by FREEZE like the cycle counter.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            presc_r   <= 32'd0;
            seconds_r <= 32'd0;
        end else if (clear_s) begin
            presc_r   <= 32'd0;
            seconds_r <= 32'd0;
        end else if (!freeze_r) begin
            if (presc_wrap_s) begin
                presc_r   <= 32'd0;
                seconds_r <= seconds_r + 32'd1;
            end else begin
                presc_r   <= presc_r + 32'd1;
                seconds_r <= seconds_r;
            end
        end else begin
            presc_r   <= presc_r;
            seconds_r <= seconds_r;
        end
    end

    // High-word capture: taken from the pre-increment count on a LO read so
    // the pair is consistent across a carry out of the low word.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            hi_shadow_r <= 32'd0;
        end else if (clear_s) begin
            hi_shadow_r <= 32'd0;
        end else if (rd_lo_s) begin
            hi_shadow_r <= cyc_r[63:32];
        end else begin
            hi_shadow_r <= hi_shadow_r;
        end
    end

    // Software-writable state: scratch and the FREEZE bit.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            scratch_r <= 32'd0;
            freeze_r  <= 1'b0;
        end else begin
            if (wr_scratch_s) begin
                scratch_r <= scratch_next_s;
            end else begin
                scratch_r <= scratch_r;
            end
            if (wr_ctrl_s) begin
                freeze_r <= writedata[1];
            end else begin
                freeze_r <= freeze_r;
            end
        end
    end

    // Registered read response; data holds between reads.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            readdata_r      <= 32'd0;
            readdatavalid_r <= 1'b0;
        end else begin
            readdatavalid_r <= read;
            if (read) begin
                readdata_r <= rd_mux_s;
            end else begin
                readdata_r <= readdata_r;
            end
        end
    end

    assign readdata      = readdata_r;
    assign readdatavalid = readdatavalid_r;

endmodule

// File: tb/tb_niosii_system_sysid_timer.sv
// -----------------------------------------------------------------------------
// Testbench for niosii_system_sysid_timer. The reference model tracks one
// "unfrozen edges since clear" tick count; the cycle counter is that count and
// SECONDS is that count divided by the clock frequency.
// -----------------------------------------------------------------------------
module tb_niosii_system_sysid_timer;

    localparam logic [31:0] SID  = 32'h52F8_EDC6;
    localparam logic [31:0] TS   = 32'h4D2A_1B00;
    localparam int          FREQ = 10;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [2:0]  address = 3'd0;
    logic        read = 1'b0;
    logic        write = 1'b0;
    logic [31:0] writedata = 32'd0;
    logic [3:0]  byteenable = 4'd0;
    logic [31:0] readdata;
    logic        readdatavalid;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    longint unsigned m_ticks = 64'd0;
    logic [31:0]     m_hi = 32'd0;
    logic [31:0]     m_scratch = 32'd0;
    logic            m_freeze = 1'b0;
    logic [31:0]     exp_rd = 32'd0;
    logic            exp_rdv = 1'b0;

    niosii_system_sysid_timer #(
        .SYSTEM_ID   (SID),
        .TIMESTAMP   (TS),
        .CLK_FREQ_HZ (FREQ)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .address       (address),
        .read          (read),
        .write         (write),
        .writedata     (writedata),
        .byteenable    (byteenable),
        .readdata      (readdata),
        .readdatavalid (readdatavalid)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] ref_read(input logic [2:0] a);
        longint unsigned secs;
        secs = m_ticks / longint'(FREQ);
        case (a)
            3'd0:    return SID;
            3'd1:    return TS;
            3'd2:    return m_ticks[31:0];
            3'd3:    return m_hi;
            3'd4:    return secs[31:0];
            3'd5:    return m_scratch;
            3'd6:    return {30'd0, m_freeze, 1'b0};
            default: return 32'd0;
        endcase
    endfunction

    // One bus cycle: drive, take the edge, advance the model, release strobes.
    task automatic do_cycle(input logic rd, input logic wr, input logic [2:0] a,
                            input logic [31:0] wd, input logic [3:0] be);
        read = rd; write = wr; address = a; writedata = wd; byteenable = be;
        if (rd) exp_rd = ref_read(a);
        exp_rdv = rd;
        @(posedge clock);
        if (rd && a == 3'd2) m_hi = m_ticks[63:32];
        if (!m_freeze) m_ticks = m_ticks + 64'd1;
        if (wr && a == 3'd5) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) m_scratch[8*i +: 8] = wd[8*i +: 8];
            end
        end
        if (wr && a == 3'd6 && be[0]) begin
            m_freeze = wd[1];
            if (wd[0]) begin
                m_ticks = 64'd0;
                m_hi    = 32'd0;
            end
        end
        #1;
        read = 1'b0; write = 1'b0;
    endtask

    task automatic model_reset();
        m_ticks = 64'd0; m_hi = 32'd0; m_scratch = 32'd0; m_freeze = 1'b0;
        exp_rd = 32'd0; exp_rdv = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clock);
        @(posedge clock);
        #1;
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        do_reset();
        n_tests++;
        if (readdata !== 32'd0 || readdatavalid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: got rd=%h rdv=%b expected 0/0", readdata, readdatavalid);
        end
    endtask

    task automatic test_id_regs();
        logic [2:0]  addrs [4] = '{3'd0, 3'd1, 3'd5, 3'd7};
        logic [31:0] want  [4] = '{SID, TS, 32'd0, 32'd0};
        for (int i = 0; i < 4; i++) begin
            do_cycle(1'b1, 1'b0, addrs[i], 32'd0, 4'd0);
            n_tests++;
            if (readdatavalid !== 1'b1 || readdata !== want[i]) begin
                n_fail++;
                $display("FAIL id_read_%0d: got %h rdv=%b expected %h rdv=1", addrs[i], readdata, readdatavalid, want[i]);
            end
        end
        do_cycle(1'b0, 1'b0, 3'd0, 32'd0, 4'd0);
        n_tests++;
        if (readdatavalid !== 1'b0 || readdata !== 32'd0) begin
            n_fail++;
            $display("FAIL idle_hold: got %h rdv=%b expected 00000000 rdv=0", readdata, readdatavalid);
        end
    endtask

    task automatic test_scratch();
        do_cycle(1'b0, 1'b1, 3'd5, 32'hAABB_CCDD, 4'b1111);
        do_cycle(1'b0, 1'b1, 3'd5, 32'h1122_3344, 4'b0101);
        do_cycle(1'b1, 1'b0, 3'd5, 32'd0, 4'd0);
        n_tests++;
        if (readdata !== 32'hAA22_CC44) begin
            n_fail++;
            $display("FAIL scratch_lanes: got %h expected aa22cc44", readdata);
        end
        do_cycle(1'b0, 1'b1, 3'd0, 32'h1234_5678, 4'b1111);
        do_cycle(1'b1, 1'b0, 3'd0, 32'd0, 4'd0);
        n_tests++;
        if (readdata !== SID) begin
            n_fail++;
            $display("FAIL id_write_ignored: got %h expected %h", readdata, SID);
        end
        // Simultaneous read and write returns the pre-write value.
        do_cycle(1'b1, 1'b1, 3'd5, 32'h0BAD_F00D, 4'b1111);
        n_tests++;
        if (readdata !== 32'hAA22_CC44) begin
            n_fail++;
            $display("FAIL rw_same_cycle: got %h expected aa22cc44", readdata);
        end
        do_cycle(1'b1, 1'b0, 3'd5, 32'd0, 4'd0);
        n_tests++;
        if (readdata !== 32'h0BAD_F00D) begin
            n_fail++;
            $display("FAIL write_visible: got %h expected 0badf00d", readdata);
        end
    endtask

    task automatic test_tear_free();
        logic [31:0] lo;
        // Case A: read LO while cyc = 0x0_FFFFFFFF.
        force dut.cyc_r = 64'h0000_0000_FFFF_FFFF;
        #1;
        release dut.cyc_r;
        m_ticks = 64'h0000_0000_FFFF_FFFF;
        do_cycle(1'b1, 1'b0, 3'd2, 32'd0, 4'd0);
        lo = readdata;
        n_tests++;
        if (readdata !== exp_rd || readdata !== 32'hFFFF_FFFF) begin
            n_fail++;
            $display("FAIL tear_lo_a: got %h expected ffffffff", readdata);
        end
        do_cycle(1'b1, 1'b0, 3'd3, 32'd0, 4'd0);
        n_tests++;
        if (readdata !== exp_rd || readdata !== 32'd0 || (lo == 32'd0 && readdata == 32'd0)) begin
            n_fail++;
            $display("FAIL tear_hi_a: got %h expected 00000000", readdata);
        end
        // Case B: read LO one edge after the carry.
        force dut.cyc_r = 64'h0000_0000_FFFF_FFFF;
        #1;
        release dut.cyc_r;
        m_ticks = 64'h0000_0000_FFFF_FFFF;
        do_cycle(1'b0, 1'b0, 3'd0, 32'd0, 4'd0);
        do_cycle(1'b1, 1'b0, 3'd2, 32'd0, 4'd0);
        lo = readdata;
        n_tests++;
        if (readdata !== exp_rd || readdata !== 32'd0) begin
            n_fail++;
            $display("FAIL tear_lo_b: got %h expected 00000000", readdata);
        end
        do_cycle(1'b1, 1'b0, 3'd3, 32'd0, 4'd0);
        n_tests++;
        if (readdata !== exp_rd || readdata !== 32'd1 || (lo == 32'd0 && readdata == 32'd0)) begin
            n_fail++;
            $display("FAIL tear_hi_b: got %h expected 00000001", readdata);
        end
    endtask

    task automatic test_seconds();
        do_reset();
        repeat (10) do_cycle(1'b0, 1'b0, 3'd0, 32'd0, 4'd0);
        do_cycle(1'b1, 1'b0, 3'd4, 32'd0, 4'd0);
        n_tests++;
        if (readdata !== exp_rd || readdata !== 32'd1) begin
            n_fail++;
            $display("FAIL seconds_10: got %h expected 00000001", readdata);
        end
        repeat (19) do_cycle(1'b0, 1'b0, 3'd0, 32'd0, 4'd0);
        do_cycle(1'b1, 1'b0, 3'd4, 32'd0, 4'd0);
        n_tests++;
        if (readdata !== exp_rd || readdata !== 32'd3) begin
            n_fail++;
            $display("FAIL seconds_30: got %h expected 00000003", readdata);
        end
        // FREEZE set at cycle 15 holds SECONDS at 1.
        do_reset();
        repeat (14) do_cycle(1'b0, 1'b0, 3'd0, 32'd0, 4'd0);
        do_cycle(1'b0, 1'b1, 3'd6, 32'h0000_0002, 4'b0001);
        for (int i = 0; i < 20; i++) begin
            do_cycle(1'b1, 1'b0, 3'd4, 32'd0, 4'd0);
            n_tests++;
            if (readdata !== exp_rd || readdata !== 32'd1) begin
                n_fail++;
                $display("FAIL seconds_frozen_%0d: got %h expected 00000001", i, readdata);
            end
        end
        do_cycle(1'b0, 1'b1, 3'd6, 32'h0000_0000, 4'b0001);
    endtask

    task automatic test_clear_freeze();
        logic [2:0] a;
        repeat (7) do_cycle(1'b0, 1'b0, 3'd0, 32'd0, 4'd0);
        do_cycle(1'b0, 1'b1, 3'd6, 32'h0000_0001, 4'b0001);
        do_cycle(1'b0, 1'b0, 3'd0, 32'd0, 4'd0);
        do_cycle(1'b1, 1'b0, 3'd2, 32'd0, 4'd0);
        n_tests++;
        if (readdata !== exp_rd || readdata !== 32'd1) begin
            n_fail++;
            $display("FAIL clear_lo: got %h expected 00000001", readdata);
        end
        do_cycle(1'b1, 1'b0, 3'd4, 32'd0, 4'd0);
        n_tests++;
        if (readdata !== 32'd0) begin
            n_fail++;
            $display("FAIL clear_seconds: got %h expected 00000000", readdata);
        end
        // Disabled lane 0: the clear is ignored.
        do_cycle(1'b0, 1'b1, 3'd6, 32'h0000_0003, 4'b1110);
        do_cycle(1'b0, 1'b1, 3'd6, 32'h0000_0003, 4'b0001);
        for (int i = 0; i < 6; i++) begin
            a = (i % 3 == 0) ? 3'd2 : ((i % 3 == 1) ? 3'd3 : 3'd4);
            do_cycle(1'b1, 1'b0, a, 32'd0, 4'd0);
            n_tests++;
            if (readdata !== exp_rd || readdata !== 32'd0) begin
                n_fail++;
                $display("FAIL frozen_zero_%0d: got %h expected 00000000", i, readdata);
            end
        end
        do_cycle(1'b1, 1'b0, 3'd6, 32'd0, 4'd0);
        n_tests++;
        if (readdata !== 32'h0000_0002) begin
            n_fail++;
            $display("FAIL control_read: got %h expected 00000002", readdata);
        end
        do_cycle(1'b0, 1'b1, 3'd6, 32'h0000_0000, 4'b0001);
    endtask

    task automatic test_back_to_back();
        logic        rd, wr;
        logic [2:0]  a;
        logic [31:0] wd;
        for (int i = 0; i < 300; i++) begin
            rd = ($urandom % 4 != 0);
            wr = ($urandom % 4 == 0);
            a  = 3'($urandom % 8);
            wd = $urandom;
            if (a == 3'd6 && ($urandom % 8 != 0)) wd[0] = 1'b0;
            if (a == 3'd6 && ($urandom % 2 == 0)) wd[1] = 1'b0;
            do_cycle(rd, wr, a, wd, 4'($urandom % 16));
            n_tests++;
            if (readdatavalid !== exp_rdv || readdata !== exp_rd) begin
                n_fail++;
                $display("FAIL random_%0d addr=%0d: got %h rdv=%b expected %h rdv=%b", i, a, readdata, readdatavalid, exp_rd, exp_rdv);
            end
        end
    endtask

    task automatic test_reset_midread();
        do_cycle(1'b0, 1'b1, 3'd5, 32'hCAFE_0001, 4'b1111);
        do_cycle(1'b1, 1'b0, 3'd5, 32'd0, 4'd0);
        n_tests++;
        if (readdatavalid !== 1'b1) begin
            n_fail++;
            $display("FAIL midread_pre: got rdv=%b expected 1", readdatavalid);
        end
        #1;
        reset = 1'b1;
        #1;
        n_tests++;
        if (readdatavalid !== 1'b0 || readdata !== 32'd0) begin
            n_fail++;
            $display("FAIL midread_async: got rd=%h rdv=%b expected 0/0", readdata, readdatavalid);
        end
        @(posedge clock);
        #1;
        reset = 1'b0;
        model_reset();
        do_cycle(1'b1, 1'b0, 3'd5, 32'd0, 4'd0);
        n_tests++;
        if (readdatavalid !== 1'b1 || readdata !== 32'd0) begin
            n_fail++;
            $display("FAIL post_reset_scratch: got %h rdv=%b expected 00000000 rdv=1", readdata, readdatavalid);
        end
        do_cycle(1'b1, 1'b0, 3'd6, 32'd0, 4'd0);
        n_tests++;
        if (readdata !== 32'd0) begin
            n_fail++;
            $display("FAIL post_reset_control: got %h expected 00000000", readdata);
        end
        do_cycle(1'b1, 1'b0, 3'd2, 32'd0, 4'd0);
        n_tests++;
        if (readdata !== exp_rd || readdata !== 32'd2) begin
            n_fail++;
            $display("FAIL post_reset_cyc: got %h expected 00000002", readdata);
        end
    endtask

    initial begin
        test_reset();
        test_id_regs();
        test_scratch();
        test_tear_free();
        test_seconds();
        test_clear_freeze();
        test_back_to_back();
        test_reset_midread();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
